// File: rtl/fust_mq.sv
// fust_mq: multi-entry matrix functional-unit status queue.
// Tracks up to NENT in-flight matrix ops with producer-tag wakeup,
// lowest-index ready select for issue, completion free and spec flush.

// Per-entry slot: holds op row, tags, spec bit and FREE/WAIT/READY/EXEC state.
module fust_mq_ent #(
   parameter int TAGW = 3,
   parameter int OPW  = 32
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            alloc,
   input  logic [OPW-1:0]  a_op,
   input  logic            a_spec,
   input  logic [TAGW-1:0] a_t1,
   input  logic [TAGW-1:0] a_t2,
   input  logic            wb_en,
   input  logic [TAGW-1:0] wb_tag,
   input  logic            iss,
   input  logic            done,
   input  logic            flush,
   input  logic            resolve,
   output logic            busy,
   output logic            rdy,
   output logic            spec,
   output logic [OPW-1:0]  op
);
   logic            exec_q;
   logic [TAGW-1:0] t1_q, t2_q;
   logic            wb_hit;

   assign wb_hit = wb_en && (wb_tag != '0);
   // READY = occupied, not executing, both operands available
   assign rdy = busy && !exec_q && (t1_q == '0) && (t2_q == '0);

   // entry state: flush beats everything, then alloc, then wakeup/issue/done/resolve
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         busy   <= 1'b0;
         exec_q <= 1'b0;
         spec   <= 1'b0;
         op     <= '0;
         t1_q   <= '0;
         t2_q   <= '0;
      end else if (flush && spec) begin
         busy   <= 1'b0;
         exec_q <= 1'b0;
         spec   <= 1'b0;
         op     <= '0;
         t1_q   <= '0;
         t2_q   <= '0;
      end else if (alloc) begin
         busy   <= 1'b1;
         exec_q <= 1'b0;
         spec   <= a_spec;
         op     <= a_op;
         t1_q   <= a_t1;
         t2_q   <= a_t2;
      end else if (busy) begin
         if (wb_hit && (t1_q == wb_tag)) t1_q <= '0;
         if (wb_hit && (t2_q == wb_tag)) t2_q <= '0;
         if (iss) exec_q <= 1'b1;
         if (resolve && !flush) spec <= 1'b0;
         if (done && exec_q) begin
            busy   <= 1'b0;
            exec_q <= 1'b0;
            spec   <= 1'b0;
            op     <= '0;
            t1_q   <= '0;
            t2_q   <= '0;
         end
      end
   end
endmodule

module fust_mq #(
   parameter int NENT = 4,
   parameter int TAGW = 3,
   parameter int OPW  = 32,
   localparam int IW  = $clog2(NENT),
   localparam int CW  = $clog2(NENT) + 1
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            alloc_en,
   input  logic [OPW-1:0]  alloc_op,
   input  logic            alloc_spec,
   input  logic [TAGW-1:0] alloc_t1,
   input  logic [TAGW-1:0] alloc_t2,
   output logic            alloc_ready,
   output logic [IW-1:0]   alloc_idx,
   input  logic            wb_en,
   input  logic [TAGW-1:0] wb_tag,
   output logic            issue_ready,
   output logic [IW-1:0]   issue_idx,
   output logic [OPW-1:0]  issue_op,
   input  logic            issue_en,
   input  logic            done_en,
   input  logic [IW-1:0]   done_idx,
   input  logic            flush,
   input  logic            resolve,
   output logic [NENT-1:0] busy_vec,
   output logic [CW-1:0]   count
);
   logic [NENT-1:0]           rdy, spec;
   logic [NENT-1:0][OPW-1:0]  op_q;
   logic                      any_rdy, acc, wb_hit;
   logic                      a_spec;
   logic [TAGW-1:0]           a_t1, a_t2;

   assign wb_hit = wb_en && (wb_tag != '0);
   // a speculative allocation racing a flush is dropped
   assign acc    = alloc_en && alloc_ready && !(flush && alloc_spec);
   // resolve applies to the incoming op too; flush already dropped spec allocs
   assign a_spec = alloc_spec && !resolve;
   // same-cycle writeback bypass into the allocated tags
   assign a_t1   = (wb_hit && (alloc_t1 == wb_tag)) ? '0 : alloc_t1;
   assign a_t2   = (wb_hit && (alloc_t2 == wb_tag)) ? '0 : alloc_t2;

   // lowest-index FREE entry for allocation
   always_comb begin
      alloc_ready = 1'b0;
      alloc_idx   = '0;
      for (int i = NENT - 1; i >= 0; i--) begin
         if (!busy_vec[i]) begin
            alloc_ready = 1'b1;
            alloc_idx   = IW'(i);
         end
      end
   end

   // lowest-index READY entry for issue; masked if a flush kills it
   always_comb begin
      any_rdy   = 1'b0;
      issue_idx = '0;
      for (int i = NENT - 1; i >= 0; i--) begin
         if (rdy[i]) begin
            any_rdy   = 1'b1;
            issue_idx = IW'(i);
         end
      end
      issue_ready = any_rdy && !(flush && spec[issue_idx]);
      issue_op    = op_q[issue_idx];
   end

   // occupancy count from registered busy bits
   always_comb begin
      count = '0;
      for (int i = 0; i < NENT; i++) count = count + CW'(busy_vec[i]);
   end

   for (genvar i = 0; i < NENT; i++) begin : g_ent
      fust_mq_ent #(.TAGW(TAGW), .OPW(OPW)) u_ent (
         .CLK     (CLK),
         .nRST    (nRST),
         .alloc   (acc && (alloc_idx == IW'(i))),
         .a_op    (alloc_op),
         .a_spec  (a_spec),
         .a_t1    (a_t1),
         .a_t2    (a_t2),
         .wb_en   (wb_en),
         .wb_tag  (wb_tag),
         .iss     (issue_en && issue_ready && (issue_idx == IW'(i))),
         .done    (done_en && (done_idx == IW'(i))),
         .flush   (flush),
         .resolve (resolve),
         .busy    (busy_vec[i]),
         .rdy     (rdy[i]),
         .spec    (spec[i]),
         .op      (op_q[i])
      );
   end
endmodule

// File: doc/fust_mq.md
Name: fust_mq

Overview:
- Multi-entry, parametrised successor to the single-slot matrix functional-unit status table in the tensor-core scoreboard.
- Holds up to NENT in-flight matrix ops. For each op it tracks the op row, the two source-operand producer tags (t1/t2), the busy state and the speculation bit.
- Wakes up operands on writeback-tag broadcast and selects one ready op per cycle for issue to the matrix unit.
- Frees entries on completion and squashes speculative entries on flush.

Parameters:
- NENT, 4, number of entries (≥2).
- TAGW, 3, producer-tag width; tag value 0 means "no dependency".
- OPW, 32, width of the op row payload; the spec bit is carried separately.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- alloc_en  in  1  allocate request
- alloc_op  in  OPW  op row
- alloc_spec  in  1  op is speculative
- alloc_t1  in  TAGW  src1 producer tag
- alloc_t2  in  TAGW  src2 producer tag
- alloc_ready  out  1  at least one FREE entry
- alloc_idx  out  $clog2(NENT)  entry the allocation will occupy
- wb_en  in  1  writeback broadcast valid
- wb_tag  in  TAGW  tag being written back
- issue_ready  out  1  an entry is READY
- issue_idx  out  $clog2(NENT)  selected entry
- issue_op  out  OPW  op row of selected entry
- issue_en  in  1  matrix unit accepts selected entry
- done_en  in  1  execution complete
- done_idx  in  $clog2(NENT)  entry completing
- flush  in  1  squash all speculative entries
- resolve  in  1  speculation resolved correct: clear all spec bits
- busy_vec  out  NENT  per-entry non-FREE
- count  out  $clog2(NENT)+1  number of non-FREE entries

Behaviour:
- Per-entry state FREE → WAIT/READY → EXEC → FREE.
  - WAIT: t1 or t2 nonzero.
  - READY: t1 = t2 = 0.
- Reset: all entries FREE, all fields 0. Outputs after reset: busy_vec=0, count=0, issue_ready=0, alloc_ready=1, alloc_idx=0.
- Allocation:
  - Accepted when alloc_en && alloc_ready.
  - Target is the lowest-index FREE entry, reported on alloc_idx.
  - The entry becomes WAIT or READY on the next edge.
  - alloc_en while full is ignored; no state change.
- Wakeup:
  - When wb_en is high, every non-FREE entry with t1==wb_tag clears t1 on the next edge; t2 likewise. wb_tag==0 has no effect.
  - Same-cycle bypass: if the allocation's alloc_t1/alloc_t2 matches wb_tag while wb_en is high, the stored tag is 0.
  - An entry woken at edge k can issue in cycle k+1.
- Issue selection:
  - Combinational pick of the lowest-index READY entry; issue_idx/issue_op are valid whenever issue_ready=1.
  - issue_en && issue_ready moves that entry to EXEC on the next edge.
  - issue_en without issue_ready is ignored.
- Completion: done_en moves entry done_idx EXEC → FREE. done_en on a non-EXEC entry is ignored.
- Flush:
  - On the next edge, every entry with spec=1 goes to FREE with all fields cleared, in any state including EXEC. A later done_idx for that entry is ignored.
  - issue_ready is masked in the flush cycle when the selected entry has spec=1.
  - An allocation in the same cycle with alloc_spec=1 is dropped. A non-spec allocation still occurs.
- Resolve: clears spec on all entries and on any same-cycle allocation. flush && resolve together: flush wins, resolve is ignored.
- Simultaneous events:
  - done and allocation of the same entry in one cycle: alloc_ready/alloc_idx see pre-edge state, so no conflict.
  - Freed slots become allocatable the cycle after.
- count and busy_vec are registered-state derived and update on the edge.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Test Plan:
- Reset, then allocate op 0xA5 with t1=0, t2=0 → next cycle busy_vec=0001, count=1, issue_ready=1, issue_idx=0, issue_op=0xA5.
- Allocate entry 0 with t1=3, t2=5, then wb_tag=3, then wb_tag=5 → issue_ready stays 0 until the cycle after wb_tag=5, then rises; allocating t1=2 while wb_tag=2 is broadcast gives READY next cycle.
- Fill all 4 entries → alloc_ready=0, a 5th alloc_en causes no change; done_en on EXEC entry 2 → alloc_ready=1 and alloc_idx=2 next cycle.
- Entries 0 (spec, EXEC), 1 (non-spec, WAIT), 2 (spec, READY) with flush asserted plus a spec allocation → after the edge busy_vec=0010, count=1; a later done_idx=0 is ignored.
- resolve on 3 spec entries, then flush → all 3 survive. flush and resolve in the same cycle on a spec entry → the entry is freed.
- Entries 1 and 3 READY → issue_idx=1; issue_en → next cycle issue_idx=3. Assert nRST=0 mid-stream → all outputs return to reset values without waiting for a clock edge.
